// File: rtl/spi_fl_xip_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_fl_xip_pkg                                                  |
// | Brief    : Shared types and constants for the SPI flash XIP read bridge.  |
// |            SPI_FL_XIP_PREFETCH_EN adds the prefetch states.               |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_fl_xip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_ISSUE        = 3'd1,
        ST_WAIT_ACC     = 3'd2,
        ST_WAIT_DONE    = 3'd3,
        ST_RESP         = 3'd4
`ifdef SPI_FL_XIP_PREFETCH_EN
        ,
        ST_PF_ISSUE     = 3'd5,
        ST_PF_WAIT_ACC  = 3'd6,
        ST_PF_WAIT_DONE = 3'd7
`endif
    } xip_state_t;

    localparam logic [2:0] COMMTYPE_RD = 3'd1;

    localparam int CMD_LSB   = 0;
    localparam int NBITS_LSB = 8;
    localparam int DUMMY_LSB = 16;

    localparam logic [6:0] NBITS_WORD = 7'd32;

    // Flash shifts the lowest-addressed byte out first, so it lands in [31:24].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_fl_xip_buf.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_fl_xip_buf                                                  |
// | Brief    : Single tag/data/valid read-buffer entry with hit compare.       |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_fl_xip_buf #(
    parameter int TAG_W  = 22,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inval,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [DATA_W-1:0] rd_data
);

    logic              r_vld;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;

    // Invalidate has priority over a fill landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_tag  <= '0;
            r_data <= '0;
        end else if (inval) begin
            r_vld  <= 1'b0;
        end else if (wr_en) begin
            r_vld  <= 1'b1;
            r_tag  <= wr_tag;
            r_data <= wr_data;
        end
    end

    assign hit     = r_vld && (r_tag == lookup_tag);
    assign rd_data = r_data;

endmodule

`default_nettype wire

// File: rtl/spi_fl_xip_rd.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_fl_xip_rd                                                   |
// | Brief    : Read-only XIP bridge: bus reads -> SPI flash read commands,     |
// |            one-word read buffer. SPI_FL_XIP_PREFETCH_EN adds next-word     |
// |            prefetch into a second buffer.                                 |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_fl_xip_rd
    import spi_fl_xip_pkg::*;
#(
    parameter int         ADDR_W   = 24,
    parameter int         DATA_W   = 32,
    parameter logic [7:0] RD_CMD   = 8'h03,
    parameter int         RD_DUMMY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    input  logic              inval,
    output logic [ADDR_W-1:0] fl_address,
    output logic [19:0]       fl_command,
    output logic [2:0]        fl_commtype,
    output logic              fl_validflag,
    output logic [DATA_W-1:0] fl_data_in,
    input  logic              fl_tready,
    input  logic [DATA_W-1:0] fl_data_out,
    input  logic              fl_validflag_out
);

    localparam int TAG_W = ADDR_W - 2;

    xip_state_t        r_state;
    logic              r_ready;
    logic [DATA_W-1:0] r_rdata;
    logic              r_fl_validflag;
    logic [ADDR_W-1:0] r_fl_address;
    logic [TAG_W-1:0]  r_req_tag;
    logic              r_drop;

    logic [TAG_W-1:0]  w_addr_tag;
    logic [DATA_W-1:0] w_swapped;
    logic              w_rd_req;
    logic              w_fill;
    logic              w_main_hit;
    logic [DATA_W-1:0] w_main_data;
    logic              w_main_wr_en;
    logic [TAG_W-1:0]  w_main_wr_tag;
    logic [DATA_W-1:0] w_main_wr_data;
    logic [19:0]       w_fl_command;
    logic              w_unused;

    assign w_addr_tag = address[ADDR_W-1:2];
    assign w_swapped  = bswap32(fl_data_out);
    assign w_rd_req   = (r_state == ST_IDLE) && valid && (wstrb == 4'h0);
    // A word fetched across an invalidate is returned but never cached.
    assign w_fill     = fl_validflag_out && !r_drop;
    assign w_unused   = ^{wdata, address[1:0]};

`ifdef SPI_FL_XIP_PREFETCH_EN
    logic              w_pf_hit;
    logic [DATA_W-1:0] w_pf_data;
    logic              w_pf_wr_en;
    logic              w_promote;
    logic [TAG_W-1:0]  w_next_tag;
    logic              r_pf_next;

    assign w_next_tag     = r_req_tag + TAG_W'(1);
    assign w_promote      = w_rd_req && !w_main_hit && w_pf_hit;
    assign w_pf_wr_en     = (r_state == ST_PF_WAIT_DONE) && w_fill;
    assign w_main_wr_en   = ((r_state == ST_WAIT_DONE) && w_fill) || w_promote;
    assign w_main_wr_tag  = w_promote ? w_addr_tag : r_req_tag;
    assign w_main_wr_data = w_promote ? w_pf_data  : w_swapped;

    spi_fl_xip_buf #(
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_pf_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .inval      (inval),
        .wr_en      (w_pf_wr_en),
        .wr_tag     (r_req_tag),
        .wr_data    (w_swapped),
        .lookup_tag (w_addr_tag),
        .hit        (w_pf_hit),
        .rd_data    (w_pf_data)
    );
`else
    assign w_main_wr_en   = (r_state == ST_WAIT_DONE) && w_fill;
    assign w_main_wr_tag  = r_req_tag;
    assign w_main_wr_data = w_swapped;
`endif

    spi_fl_xip_buf #(
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_main_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .inval      (inval),
        .wr_en      (w_main_wr_en),
        .wr_tag     (w_main_wr_tag),
        .wr_data    (w_main_wr_data),
        .lookup_tag (w_addr_tag),
        .hit        (w_main_hit),
        .rd_data    (w_main_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_ready        <= 1'b0;
            r_rdata        <= '0;
            r_fl_validflag <= 1'b0;
            r_fl_address   <= '0;
            r_req_tag      <= '0;
            r_drop         <= 1'b0;
`ifdef SPI_FL_XIP_PREFETCH_EN
            r_pf_next      <= 1'b0;
`endif
        end else begin
            r_ready        <= 1'b0;
            r_fl_validflag <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        if (wstrb != 4'h0) begin
                            r_rdata <= '0;
                            r_ready <= 1'b1;
                            r_state <= ST_RESP;
                        end else if (w_main_hit) begin
                            r_rdata <= w_main_data;
                            r_ready <= 1'b1;
                            r_state <= ST_RESP;
`ifdef SPI_FL_XIP_PREFETCH_EN
                        end else if (w_pf_hit) begin
                            r_rdata   <= w_pf_data;
                            r_ready   <= 1'b1;
                            r_req_tag <= w_addr_tag;
                            r_pf_next <= 1'b1;
                            r_state   <= ST_RESP;
`endif
                        end else begin
                            r_req_tag    <= w_addr_tag;
                            r_fl_address <= {w_addr_tag, 2'b00};
                            r_drop       <= 1'b0;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (fl_tready) begin
                        r_fl_validflag <= 1'b1;
                        r_state        <= ST_WAIT_ACC;
                    end
                end
                ST_WAIT_ACC: begin
                    if (inval) r_drop <= 1'b1;
                    if (!fl_tready) r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (inval) r_drop <= 1'b1;
                    if (fl_validflag_out) begin
                        r_rdata <= w_swapped;
                        r_ready <= 1'b1;
                        r_state <= ST_RESP;
`ifdef SPI_FL_XIP_PREFETCH_EN
                        r_pf_next <= 1'b1;
`endif
                    end
                end
                ST_RESP: begin
`ifdef SPI_FL_XIP_PREFETCH_EN
                    if (r_pf_next) begin
                        r_pf_next    <= 1'b0;
                        r_req_tag    <= w_next_tag;
                        r_fl_address <= {w_next_tag, 2'b00};
                        r_drop       <= 1'b0;
                        r_state      <= ST_PF_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
`ifdef SPI_FL_XIP_PREFETCH_EN
                ST_PF_ISSUE: begin
                    if (fl_tready) begin
                        r_fl_validflag <= 1'b1;
                        r_state        <= ST_PF_WAIT_ACC;
                    end
                end
                ST_PF_WAIT_ACC: begin
                    if (inval) r_drop <= 1'b1;
                    if (!fl_tready) r_state <= ST_PF_WAIT_DONE;
                end
                ST_PF_WAIT_DONE: begin
                    if (inval) r_drop <= 1'b1;
                    if (fl_validflag_out) r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_fl_command                    = '0;
        w_fl_command[CMD_LSB +: 8]      = RD_CMD;
        w_fl_command[NBITS_LSB +: 7]    = NBITS_WORD;
        w_fl_command[DUMMY_LSB +: 4]    = 4'(RD_DUMMY);
    end

    assign rdata        = r_rdata;
    assign ready        = r_ready;
    assign fl_address   = r_fl_address;
    assign fl_validflag = r_fl_validflag;
    assign fl_command   = w_fl_command;
    assign fl_commtype  = COMMTYPE_RD;
    assign fl_data_in   = '0;

endmodule

`default_nettype wire

// File: tb/tb_spi_fl_xip_rd.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_fl_xip_rd                                                |
// | Brief    : Directed self-checking bench for spi_fl_xip_rd with a simple   |
// |            flash controller model.                                        |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_fl_xip_rd;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        inval = 1'b0;
    logic [23:0] fl_address;
    logic [19:0] fl_command;
    logic [2:0]  fl_commtype;
    logic        fl_validflag;
    logic [31:0] fl_data_in;
    logic        fl_tready;
    logic [31:0] fl_data_out = '0;
    logic        fl_validflag_out = 1'b0;

    logic        force_busy = 1'b0;
    logic        ctl_busy = 1'b0;
    int          ctl_cnt = 0;
    logic [23:0] ctl_addr = '0;
    int          n_pulse = 0;
    logic [23:0] last_fl_addr = '0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_fl_xip_rd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid            (valid),
        .address          (address),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .rdata            (rdata),
        .ready            (ready),
        .inval            (inval),
        .fl_address       (fl_address),
        .fl_command       (fl_command),
        .fl_commtype      (fl_commtype),
        .fl_validflag     (fl_validflag),
        .fl_data_in       (fl_data_in),
        .fl_tready        (fl_tready),
        .fl_data_out      (fl_data_out),
        .fl_validflag_out (fl_validflag_out)
    );

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        case (a)
            24'h000100: return 32'h11223344;
            24'h000200: return 32'hAABBCCDD;
            24'hFFFFFC: return 32'h01020304;
            24'h000000: return 32'h55667788;
            default:    return 32'hDEADBEEF;
        endcase
    endfunction

    // Controller model: accepts a command while idle, answers 4 cycles later.
    assign fl_tready = !ctl_busy && !force_busy;

    always @(posedge clk) begin
        fl_validflag_out <= 1'b0;
        if (fl_validflag) begin
            n_pulse      <= n_pulse + 1;
            last_fl_addr <= fl_address;
        end
        if (!ctl_busy) begin
            if (fl_validflag && fl_tready) begin
                ctl_busy <= 1'b1;
                ctl_cnt  <= 3;
                ctl_addr <= fl_address;
            end
        end else if (ctl_cnt == 0) begin
            fl_validflag_out <= 1'b1;
            fl_data_out      <= flash_word(ctl_addr);
            ctl_busy         <= 1'b0;
        end else begin
            ctl_cnt <= ctl_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (16) step();
    endtask

    task automatic start_req(input logic [23:0] a, input logic [3:0] s);
        valid   = 1'b1;
        address = a;
        wstrb   = s;
        wdata   = 32'hCAFEF00D;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        check("ready_timeout", {31'd0, ready === 1'b1}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   p0;
        int   k;
        logic seen;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_ready",      {31'd0, ready},        32'd0);
        check("rst_rdata",      rdata,                 32'd0);
        check("rst_validflag",  {31'd0, fl_validflag}, 32'd0);
        check("rst_fl_address", {8'd0, fl_address},    32'd0);
        check("fl_command",     {12'd0, fl_command},   32'h0002003);
        check("fl_commtype",    {29'd0, fl_commtype},  32'd1);
        check("fl_data_in",     fl_data_in,            32'd0);
        rst_n = 1'b1;
        step();

        // Miss on 0x000100
        p0 = n_pulse;
        start_req(24'h000100, 4'h0);
        wait_ready(cyc);
        check("miss1_pulses",  n_pulse - p0,             32'd1);
        check("miss1_fl_addr", {8'd0, last_fl_addr},     32'h000100);
        check("miss1_cmd",     {24'd0, fl_command[7:0]}, 32'h03);
        check("miss1_rdata",   rdata,                    32'h44332211);
        valid = 1'b0;
        step();
        check("miss1_ready_one_cycle", {31'd0, ready}, 32'd0);
        settle();

        // Hit on 0x000102 (same word)
        p0 = n_pulse;
        start_req(24'h000102, 4'h0);
        wait_ready(cyc);
        check("hit_latency", cyc,          32'd1);
        check("hit_rdata",   rdata,        32'h44332211);
        check("hit_pulses",  n_pulse - p0, 32'd0);
        valid = 1'b0;
        settle();

        // Write is acknowledged and dropped
        p0 = n_pulse;
        start_req(24'h000100, 4'hF);
        wait_ready(cyc);
        check("wr_latency", cyc,          32'd1);
        check("wr_rdata",   rdata,        32'd0);
        check("wr_pulses",  n_pulse - p0, 32'd0);
        valid = 1'b0;
        settle();
        start_req(24'h000100, 4'h0);
        wait_ready(cyc);
        check("after_wr_hit_latency", cyc,   32'd1);
        check("after_wr_hit_rdata",   rdata, 32'h44332211);
        valid = 1'b0;
        settle();

        // Miss with controller busy for 10 cycles, inval during WAIT_DONE
        p0 = n_pulse;
        force_busy = 1'b1;
        start_req(24'h000200, 4'h0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (fl_validflag || ready) seen = 1'b1;
        end
        check("stall_no_pulse", {31'd0, seen}, 32'd0);
        force_busy = 1'b0;
        k = 0;
        while (!ctl_busy && k < 50) begin
            step();
            k++;
        end
        check("stall_accept", {31'd0, ctl_busy}, 32'd1);
        step();
        inval = 1'b1;
        step();
        inval = 1'b0;
        wait_ready(cyc);
        check("inval_rdata",  rdata,        32'hDDCCBBAA);
        check("inval_pulses", n_pulse - p0, 32'd1);
        valid = 1'b0;
        settle();
        p0 = n_pulse;
        start_req(24'h000200, 4'h0);
        wait_ready(cyc);
        check("inval_remiss_pulses", n_pulse - p0, 32'd1);
        check("inval_remiss_rdata",  rdata,        32'hDDCCBBAA);
        valid = 1'b0;
        settle();

        // Asynchronous reset while in WAIT_DONE
        start_req(24'h000100, 4'h0);
        k = 0;
        while (!ctl_busy && k < 50) begin
            step();
            k++;
        end
        check("rstmid_accept", {31'd0, ctl_busy}, 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("rstmid_ready",      {31'd0, ready},        32'd0);
        check("rstmid_rdata",      rdata,                 32'd0);
        check("rstmid_validflag",  {31'd0, fl_validflag}, 32'd0);
        check("rstmid_fl_address", {8'd0, fl_address},    32'd0);
        valid = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ready) seen = 1'b1;
        end
        check("stray_no_ready", {31'd0, seen}, 32'd0);
        settle();
        p0 = n_pulse;
        start_req(24'h000200, 4'h0);
        wait_ready(cyc);
        check("post_rst_miss_pulses", n_pulse - p0, 32'd1);
        check("post_rst_miss_rdata",  rdata,        32'hDDCCBBAA);
        valid = 1'b0;
        settle();

`ifdef SPI_FL_XIP_PREFETCH_EN
        // Prefetch wraps from the top word to address 0
        p0 = n_pulse;
        start_req(24'hFFFFFC, 4'h0);
        wait_ready(cyc);
        check("pf_demand_rdata", rdata, 32'h04030201);
        valid = 1'b0;
        k = 0;
        while (n_pulse < p0 + 2 && k < 50) begin
            step();
            k++;
        end
        check("pf_issued",  n_pulse - p0,         32'd2);
        check("pf_fl_addr", {8'd0, last_fl_addr}, 32'h000000);
        settle();
        p0 = n_pulse;
        start_req(24'h000000, 4'h0);
        wait_ready(cyc);
        check("pf_hit_latency", cyc,          32'd1);
        check("pf_hit_rdata",   rdata,        32'h88776655);
        check("pf_hit_pulses",  n_pulse - p0, 32'd0);
        valid = 1'b0;
        settle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
